shift_seq_engine: RTL and testbench

//   Parametrised, sequenced shift/rotate engine; successor to the free-running 8-bit serial-in shifter.
//   A start pulse optionally parallel-loads the register. The engine then performs exactly `len`

---
 rtl/shift_seq_engine.sv | 113 +++++++++++
 tb/tb_shift_seq_engine.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_engine.sv
// shift_seq_engine: sequenced shift/rotate engine.
// An accepted start optionally parallel-loads the register and latches the
// mode, direction and run length. The engine then performs exactly `len`
// shifts and pulses `done` for one cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; register holds its last value
//   ST_RUN  | one shift per enabled edge; cnt holds the remaining shifts
//   ST_DONE | done=1 for one enabled cycle; a start here is accepted
module shift_seq_engine #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               load,
  input  logic [1:0]         mode,
  input  logic               dir,
  input  logic [COUNT_W-1:0] len,
  input  logic               ser_in,
  input  logic [WIDTH-1:0]   par_in,
  output logic [WIDTH-1:0]   par_out,
  output logic               ser_out,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] MODE_SHIFT_IN   = 2'b00;
  localparam logic [1:0] MODE_ROTATE     = 2'b01;
  localparam logic [1:0] MODE_SHIFT_ZERO = 2'b10;
  localparam logic [1:0] MODE_ARITH      = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t             state_q, state_nxt;
  logic [WIDTH-1:0]   sh_reg_q, sh_reg_nxt;
  logic [COUNT_W-1:0] cnt_q, cnt_nxt;
  logic [1:0]         mode_q, mode_nxt;
  logic               dir_q, dir_nxt;
  logic               fill;
  logic [WIDTH-1:0]   shifted;

  // Fill bit and one-step shift result, using only the latched mode/dir.
  always_comb begin
    fill = 1'b0;
    case (mode_q)
      MODE_SHIFT_IN:   fill = ser_in;
      MODE_ROTATE:     fill = dir_q ? sh_reg_q[0] : sh_reg_q[WIDTH-1];
      MODE_SHIFT_ZERO: fill = 1'b0;
      MODE_ARITH:      fill = dir_q ? sh_reg_q[WIDTH-1] : 1'b0;
      default:         fill = 1'b0;
    endcase
    shifted = dir_q ? {fill, sh_reg_q[WIDTH-1:1]} : {sh_reg_q[WIDTH-2:0], fill};
  end

  // Next-state logic: start acceptance in IDLE/DONE, counted shifting in RUN.
  always_comb begin
    state_nxt  = state_q;
    sh_reg_nxt = sh_reg_q;
    cnt_nxt    = cnt_q;
    mode_nxt   = mode_q;
    dir_nxt    = dir_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_nxt = mode;
          dir_nxt  = dir;
          cnt_nxt  = len;
          if (load) sh_reg_nxt = par_in;
          state_nxt = (len != '0) ? ST_RUN : ST_DONE;
        end else if (state_q == ST_DONE) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        sh_reg_nxt = shifted;
        cnt_nxt    = cnt_q - COUNT_W'(1);
        if (cnt_q == COUNT_W'(1)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; ena=0 freezes everything, reset acts regardless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sh_reg_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 2'b00;
      dir_q    <= 1'b0;
    end else if (ena) begin
      state_q  <= state_nxt;
      sh_reg_q <= sh_reg_nxt;
      cnt_q    <= cnt_nxt;
      mode_q   <= mode_nxt;
      dir_q    <= dir_nxt;
    end
  end

  assign par_out = sh_reg_q;
  assign ser_out = dir_q ? sh_reg_q[0] : sh_reg_q[WIDTH-1];
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq_engine.sv
// Self-checking bench for shift_seq_engine (WIDTH=8, COUNT_W=4).
module tb_shift_seq_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       dir = 1'b0;
  logic [3:0] len = 4'd0;
  logic       ser_in = 1'b0;
  logic [7:0] par_in = 8'h00;
  logic [7:0] par_out;
  logic       ser_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [7:0] mv = 8'h00;
  logic       last_dir = 1'b0;

  shift_seq_engine #(.WIDTH(8), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .load(load),
    .mode(mode), .dir(dir), .len(len), .ser_in(ser_in), .par_in(par_in),
    .par_out(par_out), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One shift of an 8-bit value as an arithmetic operation on integers.
  function automatic logic [7:0] shift_once(input logic [7:0] v, input logic [1:0] md,
                                            input logic dr, input logic b);
    int x, f, r;
    x = int'(v);
    case (md)
      2'b00: f = int'(b);
      2'b01: f = dr ? (x % 2) : (x / 128);
      2'b10: f = 0;
      default: f = dr ? (x / 128) : 0;
    endcase
    r = dr ? (f * 128 + x / 2) : ((x * 2 + f) % 256);
    return r[7:0];
  endfunction

  // Whole-run result for the modes that do not consume serial input.
  function automatic logic [7:0] closed_form(input logic [7:0] v, input logic [1:0] md,
                                             input logic dr, input int n);
    int x, k, sx, r;
    x = int'(v);
    r = x;
    case (md)
      2'b01: begin
        k = n % 8;
        r = dr ? ((x >> k) | (x << (8 - k))) : ((x << k) | (x >> (8 - k)));
      end
      2'b10: r = dr ? (x >> n) : (x << n);
      default: begin
        sx = (x >= 128) ? x - 256 : x;
        r  = dr ? (sx >>> n) : (x << n);
      end
    endcase
    return r[7:0];
  endfunction

  task automatic chk_outputs(input string tag, input logic exp_busy, input logic exp_done);
    chk_val({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    chk_val({tag, "_done"}, 32'(done), 32'(exp_done));
    chk_val({tag, "_par"}, 32'(par_out), 32'(mv));
    chk_val({tag, "_ser"}, 32'(ser_out), 32'(last_dir ? mv[0] : mv[7]));
  endtask

  // Issue one start and follow the run to its done cycle, checking every cycle.
  task automatic do_op(input logic ld, input logic [7:0] pv, input logic [1:0] md,
                       input logic dr, input logic [3:0] ln, input logic [15:0] bits,
                       input int gap_pos, input int gap_len, input logic inj,
                       output int ncyc);
    int remaining, k, gap_left;
    logic [7:0] start_val;
    start = 1'b1; load = ld; par_in = pv; mode = md; dir = dr; len = ln;
    ena = 1'b1; ser_in = 1'($urandom);
    tick();
    start = 1'b0;
    load = 1'($urandom); par_in = 8'($urandom); mode = 2'($urandom);
    dir = 1'($urandom); len = 4'($urandom);
    if (ld) mv = pv;
    last_dir  = dr;
    start_val = mv;
    remaining = int'(ln);
    k = 0;
    gap_left = gap_len;
    ncyc = 1;
    while (remaining > 0 && ncyc < 100) begin
      chk_outputs("run", 1'b1, 1'b0);
      start = inj;
      if (k == gap_pos && gap_left > 0) begin
        ena = 1'b0;
        gap_left--;
      end else begin
        ena = 1'b1;
      end
      ser_in = bits[k];
      tick();
      ncyc++;
      if (ena) begin
        mv = shift_once(mv, md, dr, bits[k]);
        k++;
        remaining--;
      end
    end
    chk_val("run_bound", 32'(remaining), 32'd0);
    start = 1'b0;
    ena = 1'b1;
    chk_outputs("fin", 1'b0, 1'b1);
    chk_val("latency", 32'(ncyc - 1), 32'(int'(ln) + gap_len));
    if (md != 2'b00)
      chk_val("closed_form", 32'(par_out), 32'(closed_form(start_val, md, dr, int'(ln))));
  endtask

  task automatic idle_tick();
    start = 1'b0;
    ena = 1'b1;
    tick();
    chk_outputs("idle", 1'b0, 1'b0);
  endtask

  initial begin
    int nc;
    int l, gl, gp;
    logic [1:0] md;

    repeat (2) tick();
    chk_outputs("reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    idle_tick();

    // start with ena=0 is not sampled
    start = 1'b1; load = 1'b1; par_in = 8'hE7; len = 4'd3; ena = 1'b0;
    tick();
    start = 1'b0; ena = 1'b1;
    chk_outputs("ena_off", 1'b0, 1'b0);

    // reset mid-run aborts asynchronously
    start = 1'b1; load = 1'b1; par_in = 8'hC3; mode = 2'b01; dir = 1'b0; len = 4'd9;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk_val("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    mv = 8'h00; last_dir = 1'b0;
    chk_outputs("async_rst", 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    tick();
    chk_outputs("post_rst", 1'b0, 1'b0);

    do_op(1'b1, 8'hA5, 2'b01, 1'b0, 4'd4, 16'h0000, 0, 0, 1'b0, nc);
    chk_val("rot_a5", 32'(par_out), 32'h5A);
    idle_tick();

    do_op(1'b1, 8'h00, 2'b00, 1'b0, 4'd8, 16'h004D, 0, 0, 1'b0, nc);
    chk_val("shin_b2", 32'(par_out), 32'hB2);
    idle_tick();

    do_op(1'b1, 8'h90, 2'b11, 1'b1, 4'd3, 16'h0000, 0, 0, 1'b0, nc);
    chk_val("arith_f2", 32'(par_out), 32'hF2);
    // back-to-back start from DONE
    do_op(1'b1, 8'h90, 2'b10, 1'b1, 4'd3, 16'h0000, 0, 0, 1'b0, nc);
    chk_val("zero_12", 32'(par_out), 32'h12);
    idle_tick();

    do_op(1'b1, 8'h3C, 2'b01, 1'b0, 4'd0, 16'h0000, 0, 0, 1'b0, nc);
    chk_val("len0_par", 32'(par_out), 32'h3C);
    chk_val("len0_cyc", 32'(nc), 32'd1);
    idle_tick();

    do_op(1'b1, 8'h81, 2'b01, 1'b0, 4'd5, 16'h0000, 2, 2, 1'b1, nc);
    chk_val("stretch_cyc", 32'(nc - 1), 32'd7);
    idle_tick();

    for (int i = 0; i < 60; i++) begin
      md = 2'($urandom_range(0, 3));
      l  = $urandom_range(0, 15);
      gl = (l > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      gp = (l > 0) ? $urandom_range(0, l - 1) : 0;
      do_op(1'($urandom), 8'($urandom), md, 1'($urandom), 4'(l), 16'($urandom),
            gp, gl, 1'($urandom), nc);
      if ($urandom_range(0, 1) == 1) idle_tick();
    end
    idle_tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
